// File: rtl/tt_cpu_pkg.sv
// Shared definitions for the 6-bit TinyTapeout accumulator CPU and its
// memory-side responder: bus widths, the unprogrammed store word, the
// instruction encodings, and the responder's operating state.
package tt_cpu_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 6;

    // Contents of every store entry after reset or when not yet programmed.
    localparam logic [DATA_W-1:0] FILL_WORD = 6'h3C;

    // Instruction word encodings, so programs can be assembled symbolically.
    localparam logic [DATA_W-1:0] OP_ADD  = 6'h01;
    localparam logic [DATA_W-1:0] OP_SUB  = 6'h02;
    localparam logic [DATA_W-1:0] OP_SWAP = 6'h03;
    localparam logic [DATA_W-1:0] OP_OUT  = 6'h04;
    localparam logic [DATA_W-1:0] OP_JZ   = 6'h05;
    localparam logic [DATA_W-1:0] OP_JMP  = 6'h06;
    localparam logic [DATA_W-1:0] OP_IMM  = 6'h07;
    localparam logic [DATA_W-1:0] OP_HALT = 6'h3F;

    // RUN serves the CPU; LOAD streams a new program in while the CPU is held in reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } resp_state_e;

endpackage

// File: rtl/tt_sync_fifo.sv
// Small synchronous FIFO holding values the CPU emits on its output strobe.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module tt_sync_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic [DATA_W-1:0]   store [DEPTH];
    logic                do_pop;
    logic                do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = store[rd_ptr[PTR_W-1:0]];

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Data slots carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/tt_prog_mem_responder.sv
// Memory-side responder for the 6-bit accumulator CPU. Serves instruction and
// operand reads from a 64-entry program store, captures strobed output values
// into a FIFO, and streams new programs into the store while holding the CPU
// in reset.
module tt_prog_mem_responder #(
    parameter int                         ADDR_W    = tt_cpu_pkg::ADDR_W,
    parameter int                         DATA_W    = tt_cpu_pkg::DATA_W,
    parameter int                         OUT_DEPTH = 8,
    parameter logic [tt_cpu_pkg::DATA_W-1:0] FILL_WORD = tt_cpu_pkg::FILL_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_strobe,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_reset,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    input  logic              prog_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow
);

    import tt_cpu_pkg::*;

    localparam int                MEM_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    resp_state_e         state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic                load_wr;
    logic                strobe_q;
    logic                cap_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;

    assign prog_ready = (state == ST_LOAD);
    assign load_wr    = prog_valid & prog_ready;
    assign cpu_reset  = reset | (state == ST_LOAD);

    // The CPU is in reset during LOAD, so it sees the fill word rather than a half-written program.
    assign cpu_data = (state == ST_LOAD) ? DATA_W'(FILL_WORD) : mem[cpu_addr];

    assign cap_push  = cpu_strobe & ~strobe_q;
    assign fifo_pop  = out_ready & ~fifo_empty;
    assign out_valid = ~fifo_empty;

    // Load FSM: enter on prog_start, leave on prog_done or after writing the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            wr_ptr <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (prog_start) begin
                        state  <= ST_LOAD;
                        wr_ptr <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (prog_start) wr_ptr <= '0;
                    if (prog_done || (load_wr && (wr_ptr == LAST_ADDR))) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Program store: reset restores the fill word everywhere, loads write one word per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= DATA_W'(FILL_WORD);
        end else if (load_wr) begin
            mem[wr_ptr] <= prog_data;
        end
    end

    // Strobe edge history and sticky overflow on a capture dropped by a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
            overflow <= 1'b0;
        end else begin
            strobe_q <= cpu_strobe;
            if (cap_push & fifo_full & ~fifo_pop) overflow <= 1'b1;
        end
    end

    tt_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_push),
        .push_data (DATA_W'(cpu_addr)),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_tt_prog_mem_responder.sv
// Bench for tt_prog_mem_responder: a reference store and a scoreboard queue of
// expected FIFO contents are maintained alongside the stimulus.
module tb_tt_prog_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] cpu_addr;
    logic       cpu_strobe;
    logic [5:0] cpu_data;
    logic       cpu_reset;
    logic       prog_start;
    logic       prog_valid;
    logic [5:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic       out_valid;
    logic [5:0] out_data;
    logic       out_ready;
    logic       overflow;

    int check_cnt = 0;
    int fail_cnt  = 0;

    logic [5:0] m_mem [64];
    logic [5:0] exp_q [$];
    logic       m_strobe_q;
    logic       m_ovf;

    localparam logic [5:0] FILL = 6'h3C;

    tt_prog_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_strobe (cpu_strobe),
        .cpu_data   (cpu_data),
        .cpu_reset  (cpu_reset),
        .prog_start (prog_start),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = FILL;
        exp_q.delete();
        m_strobe_q = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cpu_strobe = 1'b0; prog_start = 1'b0;
        prog_valid = 1'b0; prog_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle of FIFO-side stimulus; head/valid/overflow compared with the scoreboard.
    task automatic fifo_cycle(input logic stb, input logic [5:0] a, input logic rdy);
        logic push, pop, full_b;
        cpu_strobe = stb; cpu_addr = a; out_ready = rdy;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== (exp_q.size() != 0)) begin
            fail_cnt++;
            $display("FAIL out_valid: got=%b exp=%b", out_valid, exp_q.size() != 0);
        end
        check_cnt++;
        if (overflow !== m_ovf) begin
            fail_cnt++;
            $display("FAIL overflow: got=%b exp=%b", overflow, m_ovf);
        end
        if (exp_q.size() != 0) begin
            check_cnt++;
            if (out_data !== exp_q[0]) begin
                fail_cnt++;
                $display("FAIL out_data: got=%0d exp=%0d", out_data, exp_q[0]);
            end
        end
        full_b = (exp_q.size() == 8);
        pop    = rdy && (exp_q.size() != 0);
        push   = stb && !m_strobe_q;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (full_b && !pop) m_ovf = 1'b1;
            else exp_q.push_back(a);
        end
        m_strobe_q = stb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0 || prog_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got cpu_reset=%b out_valid=%b overflow=%b prog_ready=%b exp 1 0 0 0",
                     cpu_reset, out_valid, overflow, prog_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b0) begin
            fail_cnt++;
            $display("FAIL cpu_reset_release: got=%b exp=0", cpu_reset);
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 64; a++) begin
            cpu_addr = 6'(a);
            @(negedge clk);
            check_cnt++;
            if (cpu_data !== FILL) begin
                fail_cnt++;
                $display("FAIL reset_mem addr=%0d: got=%h exp=%h", a, cpu_data, FILL);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_short();
        logic [5:0] words [6];
        words[0] = 6'd1; words[1] = 6'd2; words[2] = 6'd16;
        words[3] = 6'd6; words[4] = 6'd0; words[5] = 6'd7;
        cpu_addr = 6'd3;
        prog_start = 1'b1;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1'b1; prog_data = words[i];
            @(negedge clk);
            check_cnt++;
            if (cpu_reset !== 1'b1 || prog_ready !== 1'b1 || cpu_data !== FILL) begin
                fail_cnt++;
                $display("FAIL load_active word=%0d: got cpu_reset=%b prog_ready=%b cpu_data=%h exp 1 1 %h",
                         i, cpu_reset, prog_ready, cpu_data, FILL);
            end
            m_mem[i] = words[i];
            @(posedge clk);
            #1;
        end
        prog_valid = 1'b0; prog_done = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b1) begin
            fail_cnt++;
            $display("FAIL load_done_cycle: got cpu_reset=%b exp=1", cpu_reset);
        end
        @(posedge clk);
        #1;
        prog_done = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b0 || prog_ready !== 1'b0 || cpu_data !== 6'd6) begin
            fail_cnt++;
            $display("FAIL load_exit: got cpu_reset=%b prog_ready=%b mem[3]=%h exp 0 0 06",
                     cpu_reset, prog_ready, cpu_data);
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 64; a++) begin
            cpu_addr = 6'(a);
            @(negedge clk);
            check_cnt++;
            if (cpu_data !== m_mem[a]) begin
                fail_cnt++;
                $display("FAIL short_mem addr=%0d: got=%h exp=%h", a, cpu_data, m_mem[a]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_full();
        prog_start = 1'b1;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            prog_valid = 1'b1; prog_data = 6'(i);
            m_mem[i] = 6'(i);
            @(posedge clk);
            #1;
        end
        // LOAD must have ended by itself; this extra word must be ignored.
        prog_data = 6'h2A;
        cpu_addr = 6'd0;
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b0 || prog_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL auto_exit: got cpu_reset=%b prog_ready=%b exp 0 0", cpu_reset, prog_ready);
        end
        @(posedge clk);
        #1;
        prog_valid = 1'b0;
        for (int a = 0; a < 64; a++) begin
            cpu_addr = 6'(a);
            @(negedge clk);
            check_cnt++;
            if (cpu_data !== m_mem[a]) begin
                fail_cnt++;
                $display("FAIL full_mem addr=%0d: got=%h exp=%h", a, cpu_data, m_mem[a]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_strobe_hold();
        for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 6'd9, 1'b0);
        fifo_cycle(1'b0, 6'd9, 1'b0);
        for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 9; v++) begin
            fifo_cycle(1'b1, 6'(v), 1'b0);
            fifo_cycle(1'b0, 6'(v), 1'b0);
        end
        @(negedge clk);
        check_cnt++;
        if (overflow !== 1'b1) begin
            fail_cnt++;
            $display("FAIL overflow_set: got=%b exp=1", overflow);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) fifo_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int v = 10; v < 18; v++) begin
            fifo_cycle(1'b1, 6'(v), 1'b0);
            fifo_cycle(1'b0, 6'(v), 1'b0);
        end
        fifo_cycle(1'b1, 6'd20, 1'b1);
        fifo_cycle(1'b0, 6'd20, 1'b0);
        for (int i = 0; i < 9; i++) fifo_cycle(1'b0, 6'd0, 1'b1);
        // Push and pop together on an empty FIFO: only the push takes effect.
        fifo_cycle(1'b1, 6'd33, 1'b1);
        fifo_cycle(1'b0, 6'd33, 1'b0);
        for (int i = 0; i < 2; i++) fifo_cycle(1'b0, 6'd0, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        fifo_cycle(1'b1, 6'd5, 1'b0);
        fifo_cycle(1'b0, 6'd5, 1'b0);
        prog_start = 1'b1;
        @(posedge clk);
        #1;
        prog_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1; prog_data = 6'(40 + i);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b1) begin
            fail_cnt++;
            $display("FAIL mid_load_reset: got cpu_reset=%b exp=1", cpu_reset);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; prog_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_cnt++;
        if (cpu_reset !== 1'b0 || prog_ready !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mid_load_after: got cpu_reset=%b prog_ready=%b out_valid=%b overflow=%b exp 0 0 0 0",
                     cpu_reset, prog_ready, out_valid, overflow);
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 64; a++) begin
            cpu_addr = 6'(a);
            @(negedge clk);
            check_cnt++;
            if (cpu_data !== m_mem[a]) begin
                fail_cnt++;
                $display("FAIL mid_load_mem addr=%0d: got=%h exp=%h", a, cpu_data, m_mem[a]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_strobe = 1'b0; prog_start = 1'b0;
        prog_valid = 1'b0; prog_data = '0; prog_done = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_short();
        test_load_full();
        test_strobe_hold();
        test_overflow();
        test_back_to_back();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/tt_prog_mem_responder.md
# tt_prog_mem_responder

Memory-side responder for the 6-bit TinyTapeout accumulator CPU. It sits on the far side of the CPU's `io_out`/`io_in` pins and performs three jobs:
- answers every instruction/operand address with a 6-bit word from a 64-entry program store;
- captures values the CPU emits on its output strobe into a small FIFO;
- provides a streaming load port that fills the program store while holding the CPU in reset.

## Interface
Parameters:
- `ADDR_W`, 6, CPU address width; store depth is 2^ADDR_W.
- `DATA_W`, 6, word width returned to the CPU.
- `OUT_DEPTH`, 8, output-capture FIFO depth; power of two, ≥2.
- `FILL_WORD`, 6'h3C, reset/unprogrammed contents of every store entry.

Ports:
- `clk`  in  1  single clock, shared with the CPU.
- `reset`  in  1  synchronous, active-high.
- `cpu_addr`  in  ADDR_W  CPU address bus / output value (CPU `io_out[5:0]`).
- `cpu_strobe`  in  1  CPU output strobe (CPU `io_out[7]`).
- `cpu_data`  out  DATA_W  word for `cpu_addr` (to CPU `io_in[7:2]`).
- `cpu_reset`  out  1  reset to the CPU (to CPU `io_in[1]`).
- `prog_start`  in  1  one-cycle pulse: enter LOAD, pointer := 0.
- `prog_valid`  in  1  load word valid.
- `prog_data`  in  DATA_W  load word.
- `prog_ready`  out  1  load port accepts a word this cycle.
- `prog_done`  in  1  one-cycle pulse: leave LOAD early.
- `out_valid`  out  1  capture FIFO non-empty.
- `out_data`  out  DATA_W  FIFO head.
- `out_ready`  in  1  pop FIFO head when `out_valid`.
- `overflow`  out  1  sticky: a capture was dropped because the FIFO was full.

## Operation
States: RUN, LOAD. Reset → RUN.

Reset values:
- every store entry := `FILL_WORD`;
- FIFO empty;
- `overflow` = 0, `prog_ready` = 0, `out_valid` = 0.

`cpu_reset`:
- `cpu_reset = reset | (state == LOAD)`, combinational.

`cpu_data`:
- `cpu_data = mem[cpu_addr]`, combinational asynchronous read, valid in the same cycle.
- The CPU samples within the cycle it drives the address.
- In LOAD, `cpu_data = FILL_WORD`.

RUN:
- `prog_start` → LOAD, write pointer := 0.
- `prog_valid` is ignored; `prog_ready` = 0.

LOAD:
- `prog_ready` = 1.
- On `prog_valid & prog_ready`: `mem[ptr] := prog_data`, `ptr := ptr + 1` (ADDR_W bits).
- Write at ptr = 2^ADDR_W−1 → RUN on the next cycle; the pointer wraps to 0 and is not reused.
- `prog_done` → RUN. A write presented in the same cycle is still performed.
- `prog_start` while in LOAD restarts ptr at 0; earlier writes are kept.
- Entries not written keep their prior contents.

Output capture (both states):
- `strobe_q` registers `cpu_strobe`.
- Push `cpu_addr` when `cpu_strobe & ~strobe_q` (rising edge, sampled this cycle).
- A held-high strobe pushes exactly once.

FIFO rules:
- Pop when `out_valid & out_ready`.
- Full with push and no pop: value dropped, `overflow` := 1. It clears only on reset.
- Full with simultaneous push and pop: both occur, no overflow.
- Empty with simultaneous push and pop: pop ignored, push occurs.

Reset mid-LOAD:
- returns to RUN;
- restores `FILL_WORD` everywhere;
- FIFO emptied.

## Timing
- `cpu_data`: zero-cycle latency from `cpu_addr`.
- Load write: visible on `cpu_data` the cycle after acceptance.
- LOAD exit: `cpu_reset` falls the cycle after the last write or `prog_done`. The CPU leaves reset at pc = 0 with the new program.
- Capture: strobe rise in cycle N → `out_valid` = 1 in cycle N+1, `out_data` = `cpu_addr` sampled in N.
- Pop: head advances the cycle after `out_valid & out_ready`.
- Throughput: one load word per cycle; one pop per cycle.

## Structure
- Shared package `tt_cpu_pkg`:
  - `ADDR_W`, `DATA_W`;
  - `FILL_WORD`;
  - the CPU opcode constants (add, swap, out, jz, jmp, imm, ...) so benches assemble programs symbolically;
  - state enum {RUN, LOAD}.
- One sub-module: `tt_sync_fifo` (DATA_W × OUT_DEPTH), with push/pop/full/empty, registered pointers plus a count bit.
- Store, load FSM and edge detect live in the top.

## Test plan
- Reset only, sweep `cpu_addr` 0..63 → `cpu_data` = 6'h3C everywhere; `cpu_reset` follows `reset`; `overflow` = 0.
- `prog_start`, stream 1,2,16,6,0,7 then `prog_done` → `cpu_reset` high throughout LOAD and low the cycle after `prog_done`; `cpu_addr` = 3 reads 6; addr 6 reads 6'h3C.
- `prog_start`, 64 back-to-back words (value = index) → automatic return to RUN after word 63; `mem[63]` = 63; no wrap overwrite of `mem[0]`.
- Strobe held high 5 cycles with `cpu_addr` = 9 → exactly one FIFO entry (9); `out_valid` asserts the next cycle.
- 9 strobe pulses (values 1..9), `out_ready` = 0 → FIFO holds 1..8; `overflow` = 1; pops return 1..8 in order.
- FIFO full, strobe rise with `out_ready` = 1 in the same cycle → head popped, new value stored, `overflow` stays 0.
